// File: rtl/seqdet_test_sequencer.sv
// Test sequencer for the 4-state serial sequence detector. It clears the detector, shifts a word
// into it MSB first, and tallies the cycles in which z was high and the first bit that raised z.
module seqdet_test_sequencer #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CW = $clog2(WIDTH + 1),
   localparam int unsigned IW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic             z_in,
   output logic             w_out,
   output logic             det_resetn,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    hit_count,
   output logic             hit_valid,
   output logic [IW-1:0]    first_hit
);

   typedef enum logic [2:0] {StIdle, StClr, StShift, StDrain, StDone} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [IW-1:0]    idx_q;
   logic             sample_en;
   logic [IW-1:0]    sample_idx;

   // z is registered in the detector, so it always reports the bit applied one cycle earlier.
   assign sample_en  = z_in && (((state_q == StShift) && (idx_q != '0)) || (state_q == StDrain));
   assign sample_idx = (state_q == StDrain) ? IW'(WIDTH - 1) : idx_q - IW'(1);

   assign w_out      = (state_q == StShift) && shreg_q[WIDTH-1];
   assign det_resetn = !Reset && (state_q != StClr);

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         idx_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit_count <= '0;
         hit_valid <= 1'b0;
         first_hit <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  shreg_q   <= din;
                  hit_count <= '0;
                  hit_valid <= 1'b0;
                  first_hit <= '0;
                  busy      <= 1'b1;
                  state_q   <= StClr;
               end
            end
            StClr: begin
               idx_q   <= '0;
               state_q <= StShift;
            end
            StShift: begin
               shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
               idx_q   <= idx_q + IW'(1);
               if (idx_q == IW'(WIDTH - 1)) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               busy    <= 1'b0;
               done    <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               done    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase

         if (sample_en) begin
            hit_count <= hit_count + CW'(1);
            if (!hit_valid) begin
               first_hit <= sample_idx;
               hit_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seqdet_test_sequencer.sv
// Bench for seqdet_test_sequencer: drives a behavioural detector and checks run results,
// latency, detector reset timing, mid-run reset and back-to-back runs.
module tb_seqdet_test_sequencer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CW    = $clog2(WIDTH + 1);
   localparam int unsigned IW    = $clog2(WIDTH);

   logic             clk = 1'b0;
   logic             Reset;
   logic             start;
   logic [WIDTH-1:0] din;
   logic             z_in;
   logic             w_out;
   logic             det_resetn;
   logic             busy;
   logic             done;
   logic [CW-1:0]    hit_count;
   logic             hit_valid;
   logic [IW-1:0]    first_hit;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seqdet_test_sequencer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .start      (start),
      .din        (din),
      .z_in       (z_in),
      .w_out      (w_out),
      .det_resetn (det_resetn),
      .busy       (busy),
      .done       (done),
      .hit_count  (hit_count),
      .hit_valid  (hit_valid),
      .first_hit  (first_hit)
   );

   // Detector: S0=0, S1=1, S2=2, S3=3; z high in S3; async active-low reset.
   logic [1:0] ds = 2'd0;
   always_ff @(posedge clk or negedge det_resetn) begin
      if (!det_resetn) ds <= 2'd0;
      else begin
         case (ds)
            2'd0:    ds <= w_out ? 2'd3 : 2'd2;
            2'd1:    ds <= w_out ? 2'd0 : 2'd1;
            2'd2:    ds <= w_out ? 2'd0 : 2'd3;
            default: ds <= 2'd1;
         endcase
      end
   end
   assign z_in = (ds == 2'd3);

   function automatic int det_next(input int s, input logic b);
      case (s)
         0:       return b ? 3 : 2;
         1:       return b ? 0 : 1;
         2:       return b ? 0 : 3;
         default: return 1;
      endcase
   endfunction

   // Expected results: walk the bits MSB first through the detector rules.
   function automatic void model(input logic [WIDTH-1:0] d, output int cnt, output int vld,
                                 output int first);
      int s;
      s = 0; cnt = 0; vld = 0; first = 0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         s = det_next(s, d[WIDTH-1-i]);
         if (s == 3) begin
            if (vld == 0) first = i;
            vld = 1;
            cnt++;
         end
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One run: start pulse, wait for done, check latency, CLR timing and results.
   task automatic run_check(input string name, input logic [WIDTH-1:0] d, input int ec,
                            input int ev, input int ef, input bit poke);
      int n, rl, extra;
      bit seen;
      @(negedge clk);
      din = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1; rl = 0; seen = 0;
      chk({name, " busy_in_clr"}, int'(busy), 1);
      while (n <= 40 && !seen) begin
         if (!det_resetn) rl++;
         if (done) seen = 1;
         else begin
            if (poke) start = (n == 5);
            @(negedge clk);
            n++;
         end
      end
      start = 1'b0;
      chk({name, " done_latency"}, n, 11);
      chk({name, " det_resetn_low_cycles"}, rl, 1);
      chk({name, " busy_at_done"}, int'(busy), 0);
      chk({name, " hit_count"}, int'(hit_count), ec);
      chk({name, " hit_valid"}, int'(hit_valid), ev);
      chk({name, " first_hit"}, int'(first_hit), ef);
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk({name, " no_extra_done"}, extra, 0);
      chk({name, " held_hit_count"}, int'(hit_count), ec);
   endtask

   typedef struct {
      logic [WIDTH-1:0] d;
      int               cnt;
      int               vld;
      int               first;
      bit               poke;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int cnt, vld, first, n, ndone, t0, t1, t2;
      logic [WIDTH-1:0] d;

      vecs[0] = '{8'b1000_0000, 1, 1, 0, 1'b0};
      vecs[1] = '{8'b0000_0000, 1, 1, 1, 1'b0};
      vecs[2] = '{8'b0101_0101, 0, 0, 0, 1'b0};
      vecs[3] = '{8'b0010_0100, 2, 1, 1, 1'b1};

      Reset = 1'b1; start = 1'b0; din = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset hit_count", int'(hit_count), 0);
      chk("reset hit_valid", int'(hit_valid), 0);
      chk("reset first_hit", int'(first_hit), 0);
      chk("reset w_out", int'(w_out), 0);
      chk("reset det_resetn", int'(det_resetn), 0);
      Reset = 1'b0;
      @(negedge clk);
      chk("idle det_resetn", int'(det_resetn), 1);

      for (int i = 0; i < 4; i++)
         run_check($sformatf("vec%0d", i), vecs[i].d, vecs[i].cnt, vecs[i].vld, vecs[i].first,
                   vecs[i].poke);

      for (int i = 0; i < 12; i++) begin
         d = WIDTH'($urandom);
         model(d, cnt, vld, first);
         run_check($sformatf("rand%0d_%b", i, d), d, cnt, vld, first, 1'b0);
      end

      // Mid-SHIFT reset with a stray start pulse beforehand.
      @(negedge clk);
      din = 8'b0000_0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (n = 1; n < 6; n++) begin
         start = (n == 3);
         @(negedge clk);
      end
      start = 1'b0;
      chk("midrun busy_before_reset", int'(busy), 1);
      chk("midrun hit_count_before_reset", int'(hit_count), 1);
      Reset = 1'b1;
      #1;
      chk("midrun det_resetn_in_reset", int'(det_resetn), 0);
      @(negedge clk);
      Reset = 1'b0;
      chk("midrun busy_after", int'(busy), 0);
      chk("midrun hit_count_after", int'(hit_count), 0);
      chk("midrun hit_valid_after", int'(hit_valid), 0);
      chk("midrun first_hit_after", int'(first_hit), 0);
      chk("midrun w_out_after", int'(w_out), 0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("midrun no_activity_after", ndone, 0);

      // start held high: back-to-back runs of the same word.
      d = 8'b0010_0100;
      model(d, cnt, vld, first);
      din = d; start = 1'b1;
      ndone = 0; t0 = -1; t1 = -1; t2 = -1;
      for (int t = 1; t <= 45; t++) begin
         @(negedge clk);
         if (done) begin
            if (ndone == 0) t0 = t;
            else if (ndone == 1) t1 = t;
            else t2 = t;
            ndone++;
            chk($sformatf("held run%0d hit_count", ndone), int'(hit_count), cnt);
            chk($sformatf("held run%0d first_hit", ndone), int'(first_hit), first);
         end
         if (t == 30) start = 1'b0;
      end
      chk("held done_count", ndone, 3);
      chk("held first_done", t0, 11);
      chk("held spacing1", t1 - t0, 12);
      chk("held spacing2", t2 - t1, 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seqdet_test_sequencer.md
Name: seqdet_test_sequencer

Overview:
Controller that drives the team's 4-state serial sequence-detector FSM: clears it, shifts a loaded WIDTH-bit word into its serial input w one bit per clock (MSB first), and samples its z output after every bit. Reports the number of cycles z was high and the bit index that first produced z=1. It sits between a host or test register block and a single detector instance, and owns that detector's reset and input.

Parameters:
WIDTH, 8, number of bits shifted per run (minimum 2)
CW, $clog2(WIDTH+1), localparam; width of hit_count (WIDTH hits max, so it never saturates)
IW, $clog2(WIDTH), localparam; width of first_hit

Ports:
clk  input  1  system clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
start  input  1  run request, sampled in IDLE only
din  input  WIDTH  word to shift; latched when start is accepted
z_in  input  1  detector output z (Moore, registered in detector)
w_out  output  1  detector serial input w
det_resetn  output  1  detector active-low reset
busy  output  1  run in progress
done  output  1  one-cycle pulse, results valid
hit_count  output  CW  number of bits whose application produced z=1
hit_valid  output  1  at least one hit in last run
first_hit  output  IW  0-based index of first bit producing z=1; 0 if none

Behaviour:
- States: IDLE, CLR, SHIFT, DRAIN, DONE. State register with Reset priority.
- Reset (any state, mid-run included): state<=IDLE; busy=0, done=0, w_out=0, hit_count=0, hit_valid=0, first_hit=0, bit index=0. det_resetn=0 combinationally while Reset=1.
- IDLE: start=1 -> latch din into shift register, clear hit_count/hit_valid/first_hit, go CLR. start=0 -> stay. Previous results held in IDLE.
- CLR (1 cycle): det_resetn=0, w_out=0, busy=1 -> SHIFT, idx=0.
- SHIFT (WIDTH cycles): w_out=shreg[WIDTH-1]; shift left each cycle; idx increments. In SHIFT with idx>=1, z_in reflects bit idx-1: if z_in=1, hit_count++ and, if hit_valid=0, first_hit<=idx-1, hit_valid<=1. After idx=WIDTH-1 -> DRAIN.
- DRAIN (1 cycle): w_out=0; z_in reflects bit WIDTH-1; same hit update with index WIDTH-1 -> DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- busy=1 in CLR, SHIFT and DRAIN only. det_resetn=1 in every state except CLR (and during Reset).
- Latency: start accepted on edge k; CLR is cycle k+1, SHIFT is k+2..k+WIDTH+1, DRAIN is k+WIDTH+2, done is high in cycle k+WIDTH+3.
- start while busy or in DONE: ignored, not queued. start held high continuously: a new run begins in the cycle after DONE returns to IDLE.
- z_in is ignored outside SHIFT (idx>=1) and DRAIN; z high at reset or in CLR is never counted.
- Outputs are registered except det_resetn and w_out, which are decoded from the state and shift register.

Test Plan:
Bench detector model: S0 -w1-> S3, -w0-> S2; S1 -w1-> S0, -w0-> S1; S2 -w1-> S0, -w0-> S3; S3 -> S1 always; z=(state==S3); async active-low reset to S0.
- din=8'b1000_0000, start pulse -> done exactly 11 cycles after the start edge; hit_count=1, hit_valid=1, first_hit=0.
- din=8'b0000_0000 -> hit_count=1, first_hit=1 (S0->S2->S3->S1, then S1 holds).
- din=8'b0101_0101 -> hit_count=0, hit_valid=0, first_hit=0; det_resetn low exactly 1 cycle, in CLR.
- din=8'b0010_0100 -> hit_count=2, first_hit=1; the second hit is sampled in DRAIN (bit index 7).
- Mid-SHIFT: assert Reset for 1 cycle at idx=4 -> next cycle busy=0, all results 0, det_resetn=0 during Reset; a start pulse during a run is ignored and hit_count is unaffected.
- start held high for 30 cycles -> back-to-back runs, one done pulse every 12 cycles; each run's results match its din.
